inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 73 +++++++
 tb/tb_inst_fetch.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC register plus IF/ID pipeline register
//
// Purpose:
//   Holds the program counter, presents it to a combinational instruction ROM,
//   and registers the returned word into the IF/ID register for decode.
//   Redirects (jump) take priority over stalls (hold), and stalls take
//   priority over sequential fetch. A redirect flushes the IF/ID register,
//   so exactly one bubble reaches decode.
//
// Ports:
//   clk            in   1  clock, rising edge
//   rst            in   1  synchronous active-high reset
//   jump_en_i      in   1  redirect request from execute
//   jump_addr_i    in  32  redirect target (low two bits ignored)
//   hold_i         in   1  stall request from decode/execute
//   inst_addr_o    out 32  fetch address to the instruction ROM (the PC)
//   inst_i         in  32  ROM read data for inst_addr_o, same cycle
//   inst_o         out 32  registered instruction to decode
//   inst_addr_id_o out 32  address of inst_o
//   inst_valid_o   out  1  inst_o is a fetched instruction, not a bubble
//   fetch_cnt_o    out 32  number of instructions delivered to decode

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic [31:0] inst_addr_o,
  input  logic [31:0] inst_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_id_o,
  output logic        inst_valid_o,
  output logic [31:0] fetch_cnt_o
);

  logic [31:0] pc;
  logic [31:0] jump_target;

  // Targets are forced word-aligned; masking keeps every input bit in use.
  assign jump_target = jump_addr_i & ~32'h0000_0003;

  // The ROM address comes straight from the register, never from inputs.
  assign inst_addr_o = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      inst_o         <= NOP_INST;
      inst_addr_id_o <= 32'h0;
      inst_valid_o   <= 1'b0;
      fetch_cnt_o    <= 32'h0;
    end else if (jump_en_i) begin
      // Redirect wins over hold: the word fetched this cycle is on the
      // wrong path, so it is replaced by a bubble.
      pc             <= jump_target;
      inst_o         <= NOP_INST;
      inst_addr_id_o <= 32'h0;
      inst_valid_o   <= 1'b0;
    end else if (!hold_i) begin
      // Sequential fetch; PC arithmetic wraps naturally at 2^32.
      pc             <= pc + 32'd4;
      inst_o         <= inst_i;
      inst_addr_id_o <= pc;
      inst_valid_o   <= 1'b1;
      fetch_cnt_o    <= fetch_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch with a behavioural reference model

module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_i;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_id_o;
  logic        inst_valid_o;
  logic [31:0] fetch_cnt_o;

  logic [31:0] w_inst_addr_o;
  logic [31:0] w_inst_i;
  logic [31:0] w_inst_o;
  logic [31:0] w_inst_addr_id_o;
  logic        w_inst_valid_o;
  logic [31:0] w_fetch_cnt_o;

  int checks;
  int errors;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Reference-model state: what decode should be seeing.
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_id;
  logic        m_valid;
  logic [31:0] m_cnt;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign inst_i   = rom_word(inst_addr_o);
  assign w_inst_i = rom_word(w_inst_addr_o);

  inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .hold_i         (hold_i),
    .inst_addr_o    (inst_addr_o),
    .inst_i         (inst_i),
    .inst_o         (inst_o),
    .inst_addr_id_o (inst_addr_id_o),
    .inst_valid_o   (inst_valid_o),
    .fetch_cnt_o    (fetch_cnt_o)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk            (clk),
    .rst            (rst),
    .jump_en_i      (jump_en_i),
    .jump_addr_i    (jump_addr_i),
    .hold_i         (hold_i),
    .inst_addr_o    (w_inst_addr_o),
    .inst_i         (w_inst_i),
    .inst_o         (w_inst_o),
    .inst_addr_id_o (w_inst_addr_id_o),
    .inst_valid_o   (w_inst_valid_o),
    .fetch_cnt_o    (w_fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Advance one clock edge, stepping the model with the inputs in force
  // before the edge; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    logic [31:0] n_pc, n_inst, n_id, n_cnt;
    logic        n_valid;
    n_pc = m_pc; n_inst = m_inst; n_id = m_id; n_valid = m_valid; n_cnt = m_cnt;
    if (rst) begin
      n_pc = 32'h0; n_inst = NOP; n_id = 32'h0; n_valid = 1'b0; n_cnt = 32'h0;
    end else if (jump_en_i) begin
      n_pc = {jump_addr_i[31:2], 2'b00};
      n_inst = NOP; n_id = 32'h0; n_valid = 1'b0;
    end else if (!hold_i) begin
      n_inst = rom_word(m_pc); n_id = m_pc; n_valid = 1'b1;
      n_cnt = m_cnt + 32'd1; n_pc = m_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_inst = n_inst; m_id = n_id; m_valid = n_valid; m_cnt = n_cnt;
  endtask

  task automatic do_reset();
    rst = 1'b1; jump_en_i = 1'b0; hold_i = 1'b0; jump_addr_i = 32'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h100; hold_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_addr_o !== 32'h0 || inst_o !== 32'h13 || inst_valid_o !== 1'b0 || fetch_cnt_o !== 32'h0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d addr=%h inst=%h valid=%b cnt=%0d expected addr=0 inst=13 valid=0 cnt=0",
                 i, inst_addr_o, inst_o, inst_valid_o, fetch_cnt_o);
      end
    end
    rst = 1'b0; jump_en_i = 1'b0;
    tick();
    checks++;
    if (inst_o !== rom_word(32'h0) || inst_valid_o !== 1'b1 || inst_addr_id_o !== 32'h0 || inst_addr_o !== 32'h4) begin
      errors++;
      $display("FAIL reset_release inst=%h valid=%b id=%h addr=%h expected inst=%h valid=1 id=0 addr=4",
               inst_o, inst_valid_o, inst_addr_id_o, inst_addr_o, rom_word(32'h0));
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_addr = 32'(i * 4);
      checks++;
      if (inst_addr_o !== exp_addr) begin
        errors++;
        $display("FAIL seq_addr cyc=%0d got=%h expected=%h", i, inst_addr_o, exp_addr);
      end
      tick();
      checks++;
      if (inst_addr_id_o !== exp_addr || inst_o !== rom_word(exp_addr) || inst_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL seq_ifid cyc=%0d id=%h inst=%h valid=%b expected id=%h inst=%h valid=1",
                 i, inst_addr_id_o, inst_o, inst_valid_o, exp_addr, rom_word(exp_addr));
      end
    end
    checks++;
    if (fetch_cnt_o !== 32'd5) begin
      errors++;
      $display("FAIL seq_count got=%0d expected=5", fetch_cnt_o);
    end
  endtask

  task automatic test_hold();
    do_reset();
    tick(); tick();
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst_addr_o !== 32'h8 || inst_o !== rom_word(32'h4) || inst_addr_id_o !== 32'h4 || fetch_cnt_o !== 32'd2) begin
        errors++;
        $display("FAIL hold_frozen cyc=%0d addr=%h inst=%h id=%h cnt=%0d expected addr=8 inst=%h id=4 cnt=2",
                 i, inst_addr_o, inst_o, inst_addr_id_o, fetch_cnt_o, rom_word(32'h4));
      end
    end
    hold_i = 1'b0;
    tick();
    checks++;
    if (inst_addr_o !== 32'hC || inst_addr_id_o !== 32'h8 || inst_o !== rom_word(32'h8) || fetch_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL hold_release1 addr=%h id=%h cnt=%0d expected addr=c id=8 cnt=3", inst_addr_o, inst_addr_id_o, fetch_cnt_o);
    end
    tick();
    checks++;
    if (inst_addr_o !== 32'h10 || inst_addr_id_o !== 32'hC || inst_o !== rom_word(32'hC)) begin
      errors++;
      $display("FAIL hold_release2 addr=%h id=%h expected addr=10 id=c", inst_addr_o, inst_addr_id_o);
    end
  endtask

  task automatic test_jump();
    do_reset();
    tick(); tick(); tick();
    jump_en_i = 1'b1; jump_addr_i = 32'h43;
    tick();
    jump_en_i = 1'b0;
    checks++;
    if (inst_addr_o !== 32'h40 || inst_valid_o !== 1'b0 || inst_o !== 32'h13 || inst_addr_id_o !== 32'h0 || fetch_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL jump_bubble addr=%h valid=%b inst=%h id=%h cnt=%0d expected addr=40 valid=0 inst=13 id=0 cnt=3",
               inst_addr_o, inst_valid_o, inst_o, inst_addr_id_o, fetch_cnt_o);
    end
    tick();
    checks++;
    if (inst_o !== rom_word(32'h40) || inst_addr_id_o !== 32'h40 || inst_valid_o !== 1'b1 || fetch_cnt_o !== 32'd4) begin
      errors++;
      $display("FAIL jump_target inst=%h id=%h valid=%b cnt=%0d expected inst=%h id=40 valid=1 cnt=4",
               inst_o, inst_addr_id_o, inst_valid_o, fetch_cnt_o, rom_word(32'h40));
    end
  endtask

  task automatic test_priority();
    do_reset();
    tick(); tick();
    jump_en_i = 1'b1; hold_i = 1'b1; jump_addr_i = 32'h20;
    tick();
    jump_en_i = 1'b0; hold_i = 1'b0;
    checks++;
    if (inst_addr_o !== 32'h20 || inst_valid_o !== 1'b0 || inst_o !== 32'h13 || fetch_cnt_o !== 32'd2) begin
      errors++;
      $display("FAIL priority addr=%h valid=%b inst=%h cnt=%0d expected addr=20 valid=0 inst=13 cnt=2",
               inst_addr_o, inst_valid_o, inst_o, fetch_cnt_o);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0000_0000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_inst_addr_o !== exp_w[i]) begin
        errors++;
        $display("FAIL wrap_addr step=%0d got=%h expected=%h", i, w_inst_addr_o, exp_w[i]);
      end
      tick();
    end
    checks++;
    if (w_inst_addr_id_o !== 32'h0 || w_fetch_cnt_o !== 32'd3) begin
      errors++;
      $display("FAIL wrap_ifid id=%h cnt=%0d expected id=0 cnt=3", w_inst_addr_id_o, w_fetch_cnt_o);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(99) < 2);
      jump_en_i   = ($urandom_range(99) < 12);
      hold_i      = ($urandom_range(99) < 25);
      jump_addr_i = $urandom;
      tick();
      checks++;
      if (inst_addr_o !== m_pc || inst_o !== m_inst || inst_addr_id_o !== m_id ||
          inst_valid_o !== m_valid || fetch_cnt_o !== m_cnt) begin
        errors++;
        $display("FAIL random cyc=%0d got pc=%h inst=%h id=%h v=%b cnt=%0d expected pc=%h inst=%h id=%h v=%b cnt=%0d",
                 i, inst_addr_o, inst_o, inst_addr_id_o, inst_valid_o, fetch_cnt_o,
                 m_pc, m_inst, m_id, m_valid, m_cnt);
      end
    end
    rst = 1'b0; jump_en_i = 1'b0; hold_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    m_pc = 32'h0; m_inst = NOP; m_id = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_i = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_hold();
    test_jump();
    test_priority();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
